// File: rtl/pokey_kbd_scan.sv
// POKEY keyboard scanner: walks the 64-key matrix, debounces one key at a time,
// latches KBCODE and raises the keyboard IRQ / overrun pulses.
//
// state   | meaning
// IDLE    | no key held, looking for any pressed position
// CONFIRM | candidate seen once, waiting for the next visit to confirm it
// DOWN    | key accepted and held
// RELEASE | key seen up once, waiting for the next visit to confirm release
module pokey_kbd_scan #(
    parameter logic [5:0] SHIFT_POS = 6'h10,
    parameter logic [5:0] CTRL_POS  = 6'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scanEn,
    input  logic       kbdEnable,
    input  logic       debounceEn,
    input  logic       kr1_n,
    input  logic       kr2_n,
    input  logic       irqPending,
    output logic [5:0] kScan,
    output logic [7:0] kbcode,
    output logic       keyDown,
    output logic       kShift,
    output logic       keyOvrun,
    output logic       keyIrq
);

    typedef enum logic [1:0] {IDLE, CONFIRM, DOWN, RELEASE} state_t;

    state_t     state;
    logic [5:0] cmp;
    logic       ctrl_l;
    logic       match;
    logic       pressed;

    assign match   = (kScan == cmp);
    assign pressed = !kr1_n;

    // kShift doubles as the latched SHIFT state; accepts use the value latched
    // before the current sample, so a modifier sampled this step counts next time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmp      <= 6'h00;
            ctrl_l   <= 1'b0;
            kScan    <= 6'h00;
            kbcode   <= 8'h00;
            keyDown  <= 1'b0;
            kShift   <= 1'b0;
            keyOvrun <= 1'b0;
            keyIrq   <= 1'b0;
        end else begin
            keyIrq   <= 1'b0;
            keyOvrun <= 1'b0;
            if (!kbdEnable) begin
                kScan   <= 6'h00;
                state   <= IDLE;
                keyDown <= 1'b0;
                kShift  <= 1'b0;
            end else if (scanEn) begin
                kScan <= kScan + 6'd1;
                if (kScan == SHIFT_POS) kShift <= !kr2_n;
                if (kScan == CTRL_POS)  ctrl_l <= !kr2_n;
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            cmp <= kScan;
                            if (debounceEn) begin
                                state <= CONFIRM;
                            end else begin
                                kbcode   <= {ctrl_l, kShift, kScan};
                                keyIrq   <= 1'b1;
                                keyOvrun <= irqPending;
                                keyDown  <= 1'b1;
                                state    <= DOWN;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (match) begin
                            if (pressed) begin
                                kbcode   <= {ctrl_l, kShift, cmp};
                                keyIrq   <= 1'b1;
                                keyOvrun <= irqPending;
                                keyDown  <= 1'b1;
                                state    <= DOWN;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DOWN: begin
                        if (match && !pressed) begin
                            if (debounceEn) begin
                                state <= RELEASE;
                            end else begin
                                state   <= IDLE;
                                keyDown <= 1'b0;
                            end
                        end
                    end
                    RELEASE: begin
                        if (match) begin
                            if (pressed) begin
                                state <= DOWN;
                            end else begin
                                state   <= IDLE;
                                keyDown <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pokey_kbd_scan.md
# pokey_kbd_scan

Keyboard scan and debounce controller for the POKEY core. Walks a 6-bit scan counter across the 64-position key matrix and samples the key-response lines. A debounce state machine confirms each press before loading KBCODE. It generates the `keyDown`, `kShift` and `keyOvrun` pulses consumed by the SKSTAT register, and the keyboard IRQ request consumed by the IRQ block.

## Interface
Parameters:
- `SHIFT_POS`, 6'h10, scan position at which `kr2_n` carries the SHIFT key.
- `CTRL_POS`, 6'h00, scan position at which `kr2_n` carries the CONTROL key.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  50 MHz system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `scanEn`  in  1  one-`clk` scan strobe, one per scan step.
- `kbdEnable`  in  1  SKCTL bit 1; 0 = scanning off.
- `debounceEn`  in  1  SKCTL bit 0; 1 = two-scan confirm/release.
- `kr1_n`  in  1  key response, low = key at `kScan` pressed.
- `kr2_n`  in  1  modifier response, low = modifier at `kScan` pressed.
- `irqPending`  in  1  keyboard IRQST bit still set (not yet acknowledged).
- `kScan`  out  6  scan counter driven to the matrix.
- `kbcode`  out  8  KBCODE: {ctrl, shift, code[5:0]}.
- `keyDown`  out  1  level, key currently held (to SKSTAT).
- `kShift`  out  1  level, SHIFT currently held (to SKSTAT).
- `keyOvrun`  out  1  one-`clk` pulse, to SKSTAT overrun latch.
- `keyIrq`  out  1  one-`clk` pulse, new key accepted.

## Operation
- All state advances only on `clk` edges with `scanEn`=1; otherwise every register holds.
- On each `scanEn`:
  - Sample `kr1_n` and `kr2_n` against the current `kScan`.
  - Evaluate the FSM.
  - Then `kScan` <= `kScan`+1, wrapping 6'h3F -> 6'h00.
- Modifiers:
  - At `kScan`==SHIFT_POS: `shiftL` <= !`kr2_n`; `kShift` = `shiftL`.
  - At `kScan`==CTRL_POS: `ctrlL` <= !`kr2_n`.
- Compare register `cmp[5:0]` holds the candidate key code.
- "Match" means `kScan`==`cmp`; "pressed" means `kr1_n`==0.
- FSM states and transitions (evaluated per `scanEn`):
  - IDLE: pressed -> `cmp` <= `kScan`.
    - If `debounceEn`=1, go to CONFIRM.
    - Else do the accept action and go to DOWN.
  - CONFIRM: on match and pressed -> accept, go to DOWN. On match and not pressed -> IDLE. Non-matching presses are ignored.
  - DOWN: on match and not pressed -> RELEASE if `debounceEn`=1, else IDLE.
  - RELEASE: on match and pressed -> DOWN, with no accept. On match and not pressed -> IDLE.
- Accept action:
  - `kbcode` <= {`ctrlL`, `shiftL`, `cmp` or `kScan`}.
  - `keyIrq`=1 for one `clk`.
  - `keyOvrun`=1 for the same `clk` if `irqPending`=1.
- `keyDown`=1 in DOWN and RELEASE; 0 in IDLE and CONFIRM.
- `debounceEn` changes take effect at the next `scanEn`. A CONFIRM/RELEASE state reached earlier completes under the new rule at its next match.
- Other keys pressed while in CONFIRM, DOWN or RELEASE are ignored (single-key rollover).
- `kbdEnable`=0: synchronously, on any `clk`:
  - `kScan` <= 0 and FSM <= IDLE.
  - `keyDown`, `kShift` <= 0, and pulses stay 0.
  - `kbcode` holds.

## Timing
- Reset values: `kScan`=6'h00, `kbcode`=8'h00, `keyDown`=0, `kShift`=0, `keyOvrun`=0, `keyIrq`=0, FSM=IDLE, `cmp`=0, `shiftL`=`ctrlL`=0.
- Outputs are registered and change on the `clk` edge that samples `scanEn`=1.
- Press-to-accept latency:
  - `debounceEn`=0: the same `scanEn` that sees the press.
  - `debounceEn`=1: exactly 64 `scanEn` later, on the next visit to the same code.
- Release latency: 64 `scanEn` after the last pressed sample with `debounceEn`=0; 128 with `debounceEn`=1.
- `keyIrq` and `keyOvrun` are exactly one `clk` wide. `kbcode` is valid on the same edge as `keyIrq`.
- Asynchronous reset mid-scan returns every register to its reset value immediately. Scanning resumes at 6'h00 on the first `scanEn` after `reset_n` rises.
- `scanEn` coincident with `kbdEnable`=0: disable wins, with no sample and no advance.

## Test plan
- Reset and idle:
  - Stimulus: `reset_n`=0 mid-run, then 70 `scanEn` with no key.
  - Required: all outputs at reset values, `kScan` wraps 3F -> 00, no pulses.
- Debounced press:
  - Stimulus: `debounceEn`=1; hold key 6'h15 low on `kr1_n` with SHIFT pressed.
  - Required: `keyIrq` exactly 64 `scanEn` after the first sample; `kbcode`=8'h55; `keyDown`=1; `kShift`=1.
- Glitch rejection:
  - Stimulus: key 6'h21 pressed for one scan only, `debounceEn`=1.
  - Required: no `keyIrq`, `keyDown` stays 0, FSM back to IDLE.
- Overrun:
  - Stimulus: `irqPending`=1; second key 6'h08 accepted after the first is released.
  - Required: `keyOvrun` and `keyIrq` pulse on the same `clk`; `kbcode`=8'h08.
- Release and rollover:
  - Stimulus: hold 6'h15, press 6'h30 as well, then release 6'h15.
  - Required: 6'h30 ignored while 6'h15 is held. `keyDown` drops 128 `scanEn` after the last sample of 6'h15. 6'h30 is then accepted as a new key.
- Disable:
  - Stimulus: `kbdEnable`=0 while in DOWN.
  - Required: next `clk` gives `kScan`=0, `keyDown`=0, `kbcode` unchanged.
